call_writer: RTL and testbench

CALL_WRITER -- requirements
Module: call_writer

---
 rtl/call_writer_if.sv | 26 ++
 rtl/call_writer.sv | 119 +++++++++++
 tb/tb_call_writer.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/call_writer_if.sv
// Bundle between the call source/floor register file and call_writer.
// Master drives calls and clears; slave produces the register write word.
interface call_writer_if #(
  parameter int FLOORS = 8,
  parameter int DATA_W = 5
);
  localparam int IW = $clog2(FLOORS);

  logic [FLOORS-1:0] call_req;
  logic [FLOORS-1:0] call_dir;
  logic              clear_req;
  logic [IW-1:0]     clear_floor;
  logic [IW-1:0]     wr_regnum;
  logic [DATA_W-1:0] wr_data;
  logic              busy;

  modport master (
    output call_req, call_dir, clear_req, clear_floor,
    input  wr_regnum, wr_data, busy
  );

  modport slave (
    input  call_req, call_dir, clear_req, clear_floor,
    output wr_regnum, wr_data, busy
  );
endinterface

// File: rtl/call_writer.sv
// Turns floor call pulses and clears into one floor-register write per cycle.
// Build option CALL_WRITER_REFRESH_EN: idle cycles sweep shadow state.
module call_writer #(
  parameter int FLOORS = 8,
  parameter int DATA_W = 5
) (
  input logic         clk,
  input logic         reset,
  call_writer_if.slave bus
);
  localparam int IW = $clog2(FLOORS);

  logic [FLOORS-1:0] pending, pending_n;
  logic [FLOORS-1:0] pdir, pdir_n;
  logic [FLOORS-1:0] sh_act, sh_act_n;
  logic [FLOORS-1:0] sh_dir, sh_dir_n;
  logic [IW-1:0]     rr_ptr, rr_n;
  logic [IW-1:0]     regnum, regnum_n;
  logic [DATA_W-1:0] data, data_n;
  logic              busy_q;

  logic [FLOORS-1:0] pend_eff;
  logic [FLOORS-1:0] dir_eff;
  logic [IW-1:0]     sel;
  logic [IW-1:0]     idx;
  logic [IW-1:0]     cf;
  logic              found;

`ifdef CALL_WRITER_REFRESH_EN
  logic [IW-1:0]     ref_ptr, ref_n;
`endif

  assign bus.wr_regnum = regnum;
  assign bus.wr_data   = data;
  assign bus.busy      = busy_q;

  // Round-robin pick over pending plus this cycle's calls, from rr_ptr.
  always_comb begin
    pend_eff = pending | bus.call_req;
    dir_eff  = (pdir & ~bus.call_req)
             | (bus.call_dir & bus.call_req);
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int i = 0; i < FLOORS; i++) begin
      idx = rr_ptr + IW'(i);
      if (!found && pend_eff[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  // Write arbitration: clear beats a call, a call beats an idle write.
  always_comb begin
    cf        = bus.clear_floor;
    pending_n = pend_eff;
    pdir_n    = dir_eff;
    sh_act_n  = sh_act;
    sh_dir_n  = sh_dir;
    rr_n      = rr_ptr;
    regnum_n  = regnum;
    data_n    = data;
`ifdef CALL_WRITER_REFRESH_EN
    ref_n     = ref_ptr;
`endif
    if (bus.clear_req) begin
      pending_n[cf] = 1'b0;
      pdir_n[cf]    = pdir[cf];
      sh_act_n[cf]  = 1'b0;
      regnum_n      = cf;
      data_n        = {1'b0, sh_dir[cf], cf};
    end else if (found) begin
      pending_n[sel] = 1'b0;
      sh_act_n[sel]  = 1'b1;
      sh_dir_n[sel]  = dir_eff[sel];
      rr_n           = sel + IW'(1);
      regnum_n       = sel;
      data_n         = {1'b1, dir_eff[sel], sel};
    end else begin
`ifdef CALL_WRITER_REFRESH_EN
      regnum_n = ref_ptr;
      data_n   = {sh_act[ref_ptr], sh_dir[ref_ptr], ref_ptr};
      ref_n    = ref_ptr + IW'(1);
`endif
    end
  end

  // State and registered write word; reset drops everything at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= '0;
      pdir    <= '0;
      sh_act  <= '0;
      sh_dir  <= '0;
      rr_ptr  <= '0;
      regnum  <= '0;
      data    <= '0;
      busy_q  <= 1'b0;
    end else begin
      pending <= pending_n;
      pdir    <= pdir_n;
      sh_act  <= sh_act_n;
      sh_dir  <= sh_dir_n;
      rr_ptr  <= rr_n;
      regnum  <= regnum_n;
      data    <= data_n;
      busy_q  <= |pending_n;
    end
  end

`ifdef CALL_WRITER_REFRESH_EN
  // Refresh sweep pointer, advanced only on idle cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ref_ptr <= '0;
    else        ref_ptr <= ref_n;
  end
`endif
endmodule

// File: tb/tb_call_writer.sv
// Randomized and directed bench for call_writer.
// Reference model tracks calls as per-floor flags with modulo search.
module tb_call_writer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  call_writer_if bus ();

  call_writer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  bit       m_pend [8];
  bit       m_pdir [8];
  bit       m_act  [8];
  bit       m_dir  [8];
  int       m_rr;
  int       m_ref;
  logic [2:0] m_reg;
  logic [4:0] m_data;
  logic     m_busy;

  function automatic void m_reset();
    for (int f = 0; f < 8; f++) begin
      m_pend[f] = 0;
      m_pdir[f] = 0;
      m_act[f]  = 0;
      m_dir[f]  = 0;
    end
    m_rr = 0;
    m_ref = 0;
    m_reg = 0;
    m_data = 0;
    m_busy = 0;
  endfunction

  function automatic void m_step(
    logic [7:0] req, logic [7:0] dir, bit clr, int cf
  );
    int k;
    k = -1;
    for (int f = 0; f < 8; f++) begin
      if (req[f] && !(clr && f == cf)) begin
        m_pend[f] = 1;
        m_pdir[f] = dir[f];
      end
    end
    if (clr) begin
      m_pend[cf] = 0;
      m_act[cf] = 0;
      m_reg = 3'(cf);
      m_data = {1'b0, m_dir[cf], 3'(cf)};
    end else begin
      for (int n = 0; n < 8; n++) begin
        if (k < 0 && m_pend[(m_rr + n) % 8]) k = (m_rr + n) % 8;
      end
      if (k >= 0) begin
        m_pend[k] = 0;
        m_act[k] = 1;
        m_dir[k] = m_pdir[k];
        m_rr = (k + 1) % 8;
        m_reg = 3'(k);
        m_data = {1'b1, m_pdir[k], 3'(k)};
      end else begin
`ifdef CALL_WRITER_REFRESH_EN
        m_reg = 3'(m_ref);
        m_data = {m_act[m_ref], m_dir[m_ref], 3'(m_ref)};
        m_ref = (m_ref + 1) % 8;
`endif
      end
    end
    m_busy = 0;
    for (int f = 0; f < 8; f++) if (m_pend[f]) m_busy = 1;
  endfunction

  task automatic apply(
    logic [7:0] req, logic [7:0] dir, bit clr, int cf
  );
    bus.call_req = req;
    bus.call_dir = dir;
    bus.clear_req = clr;
    bus.clear_floor = 3'(cf);
    m_step(req, dir, clr, cf);
    @(posedge clk);
    #1;
    bus.call_req = 0;
    bus.call_dir = 0;
    bus.clear_req = 0;
    bus.clear_floor = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.call_req = 0;
    bus.call_dir = 0;
    bus.clear_req = 0;
    bus.clear_floor = 0;
    m_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1'b0;
    #2;
    vectors++;
    if ({bus.wr_regnum, bus.wr_data, bus.busy} !== 9'd0) begin
      miscompares++;
      $display("FAIL reset_state got %h/%b/%b want 0/00000/0",
               bus.wr_regnum, bus.wr_data, bus.busy);
    end
    do_reset();
    for (int c = 0; c < 4; c++) begin
      apply(0, 0, 0, 0);
      vectors++;
      if ({bus.wr_regnum, bus.wr_data, bus.busy}
          !== {m_reg, m_data, m_busy}) begin
        miscompares++;
        $display("FAIL reset_idle c%0d got %h/%b/%b want %h/%b/%b", c,
                 bus.wr_regnum, bus.wr_data, bus.busy,
                 m_reg, m_data, m_busy);
      end
    end
  endtask

  task automatic test_single_call();
    do_reset();
    apply(8'h08, 8'h08, 0, 0);
    vectors++;
    if ({bus.wr_regnum, bus.wr_data, bus.busy} !== {3'd3, 5'b11011, 1'b0}) begin
      miscompares++;
      $display("FAIL single_call got %h/%b/%b want 3/11011/0",
               bus.wr_regnum, bus.wr_data, bus.busy);
    end
  endtask

  task automatic test_dual_call();
    logic [8:0] want [2];
    want[0] = {3'd0, 5'b10000, 1'b1};
    want[1] = {3'd7, 5'b10111, 1'b0};
    do_reset();
    apply(8'h81, 8'h00, 0, 0);
    vectors++;
    if ({bus.wr_regnum, bus.wr_data, bus.busy} !== want[0]) begin
      miscompares++;
      $display("FAIL dual_call0 got %h/%b/%b want %b",
               bus.wr_regnum, bus.wr_data, bus.busy, want[0]);
    end
    apply(0, 0, 0, 0);
    vectors++;
    if ({bus.wr_regnum, bus.wr_data, bus.busy} !== want[1]) begin
      miscompares++;
      $display("FAIL dual_call1 got %h/%b/%b want %b",
               bus.wr_regnum, bus.wr_data, bus.busy, want[1]);
    end
  endtask

  task automatic test_clear_collision();
    do_reset();
    apply(8'h24, 8'h24, 1, 5);
    vectors++;
    if ({bus.wr_regnum, bus.wr_data} !== {3'd5, 5'b00101}) begin
      miscompares++;
      $display("FAIL clr_coll0 got %h/%b want 5/00101",
               bus.wr_regnum, bus.wr_data);
    end
    apply(0, 0, 0, 0);
    vectors++;
    if ({bus.wr_regnum, bus.wr_data} !== {3'd2, 5'b11010}) begin
      miscompares++;
      $display("FAIL clr_coll1 got %h/%b want 2/11010",
               bus.wr_regnum, bus.wr_data);
    end
    for (int c = 0; c < 8; c++) begin
      apply(0, 0, 0, 0);
      vectors++;
      if (bus.wr_data === 5'b10101 || bus.wr_data === 5'b11101) begin
        miscompares++;
        $display("FAIL clr_coll_f5 c%0d got %b want inactive", c,
                 bus.wr_data);
      end
    end
  endtask

  task automatic test_clear_block();
    logic [7:0] seen;
    do_reset();
    seen = 0;
    apply(8'hFF, 8'($urandom), 0, 0);
    seen[bus.wr_regnum] = bus.wr_data[4];
    for (int c = 0; c < 3; c++) begin
      apply(0, 0, 1, $urandom_range(0, 7));
      vectors++;
      if ({bus.wr_regnum, bus.wr_data, bus.busy}
          !== {m_reg, m_data, m_busy} || bus.wr_data[4] !== 1'b0) begin
        miscompares++;
        $display("FAIL clr_block c%0d got %h/%b/%b want %h/%b/%b", c,
                 bus.wr_regnum, bus.wr_data, bus.busy,
                 m_reg, m_data, m_busy);
      end
    end
    for (int c = 0; c < 8; c++) begin
      apply(0, 0, 0, 0);
      vectors++;
      if ({bus.wr_regnum, bus.wr_data, bus.busy}
          !== {m_reg, m_data, m_busy}) begin
        miscompares++;
        $display("FAIL drain c%0d got %h/%b/%b want %h/%b/%b", c,
                 bus.wr_regnum, bus.wr_data, bus.busy,
                 m_reg, m_data, m_busy);
      end
    end
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_busy got %b want 0", bus.busy);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    apply(8'hFF, 8'hFF, 0, 0);
    #3;
    reset = 1'b0;
    m_reset();
    #1;
    vectors++;
    if ({bus.wr_regnum, bus.wr_data, bus.busy} !== 9'd0) begin
      miscompares++;
      $display("FAIL reset_mid got %h/%b/%b want 0/00000/0",
               bus.wr_regnum, bus.wr_data, bus.busy);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int c = 0; c < 8; c++) begin
      apply(0, 0, 0, 0);
      vectors++;
      if ({bus.wr_regnum, bus.wr_data, bus.busy}
          !== {m_reg, m_data, m_busy} || bus.wr_data[4] !== 1'b0) begin
        miscompares++;
        $display("FAIL post_reset c%0d got %h/%b/%b want %h/%b/%b", c,
                 bus.wr_regnum, bus.wr_data, bus.busy,
                 m_reg, m_data, m_busy);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] req;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      apply(req, 8'($urandom), ($urandom_range(0, 2) == 0),
            $urandom_range(0, 7));
      vectors++;
      if ({bus.wr_regnum, bus.wr_data, bus.busy}
          !== {m_reg, m_data, m_busy}
          || bus.wr_data[2:0] !== bus.wr_regnum) begin
        miscompares++;
        $display("FAIL random c%0d got %h/%b/%b want %h/%b/%b", c,
                 bus.wr_regnum, bus.wr_data, bus.busy,
                 m_reg, m_data, m_busy);
      end
    end
  endtask

  initial begin
    bus.call_req = 0;
    bus.call_dir = 0;
    bus.clear_req = 0;
    bus.clear_floor = 0;
    test_reset();
    test_single_call();
    test_dual_call();
    test_clear_collision();
    test_clear_block();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
